// File: rtl/ysyx_24120013_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24120013_ctrl_pkg
// Shared types and widths for the sequencing controller.
//   STATE_W : width of the FSM state encoding (exported on state_o)
//   XLEN    : instruction / address width
//   state_t : FSM states with fixed debug encodings
// ---------------------------------------------------------------------------
package ysyx_24120013_ctrl_pkg;

    localparam int STATE_W = 3;
    localparam int XLEN    = 32;

    typedef enum logic [STATE_W-1:0] {
        ST_RST   = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

endpackage

// File: rtl/ysyx_24120013_fetch_timer.sv
// ---------------------------------------------------------------------------
// ysyx_24120013_fetch_timer
// Counts consecutive no-response FETCH cycles and flags the one that must
// turn into a fault.
//   clk, rst : clock, asynchronous active-low reset
//   clear    : zero the count (held while the FSM is outside FETCH)
//   tick     : this is a FETCH cycle without rvalid/err
//   expired  : this tick is the TIMEOUT-th consecutive one
// TIMEOUT = 0 disables the timer (expired is constant 0).
// ---------------------------------------------------------------------------
module ysyx_24120013_fetch_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            // The count holds the number of earlier silent cycles, so it
            // only ever needs to reach TIMEOUT-1.
            localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] wait_cnt;

            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wait_cnt <= '0;
                end else if (clear) begin
                    wait_cnt <= '0;
                end else if (tick && (wait_cnt != LAST)) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end

            // A response on the last allowed cycle wins because tick is
            // only raised when no response is present.
            assign expired = tick && (wait_cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/ysyx_24120013_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_24120013_seq_ctrl
// Multi-cycle core sequencer: RST -> FETCH -> EXEC -> FETCH ..., with
// absorbing HALT (ebreak) and FAULT (bus error / fetch timeout) states.
//   clk, rst     : clock, asynchronous active-low reset
//   pc           : current PC, forwarded as imem_addr during FETCH
//   imem_*       : instruction fetch request/response (ignored outside FETCH)
//   inst_q       : instruction latched on a clean fetch response
//   rf_wen_in/out: register-file write enable, passed only in EXEC
//   pc_update    : one-cycle PC advance pulse at the end of EXEC
//   halt_req     : decoded halt; EXEC goes to HALT instead of advancing
//   halted/fault : sticky status, state_o : debug state encoding
//   instr_cnt    : retired instructions, stall_cnt : FETCH wait cycles
// Optional feature macro YSYX_24120013_PERF_CNT_EN enables the counters;
// without it both counters are tied to 0.
// ---------------------------------------------------------------------------
module ysyx_24120013_seq_ctrl
    import ysyx_24120013_ctrl_pkg::*;
#(
    parameter int IMEM_TIMEOUT = 15,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      pc,
    output logic                 imem_req,
    output logic [XLEN-1:0]      imem_addr,
    input  logic                 imem_rvalid,
    input  logic [XLEN-1:0]      imem_rdata,
    input  logic                 imem_err,
    output logic [XLEN-1:0]      inst_q,
    input  logic                 rf_wen_in,
    output logic                 rf_wen_out,
    output logic                 pc_update,
    input  logic                 halt_req,
    output logic                 halted,
    output logic                 fault,
    output logic [STATE_W-1:0]   state_o,
    output logic [CNT_WIDTH-1:0] instr_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    state_t state, state_nxt;

    logic in_fetch;
    logic fetch_ok;
    logic wait_tick;
    logic timed_out;

    assign in_fetch  = (state == ST_FETCH);
    assign fetch_ok  = in_fetch && imem_rvalid && !imem_err;
    assign wait_tick = in_fetch && !imem_rvalid && !imem_err;

    // Clearing whenever we are outside FETCH guarantees a zero count on
    // every FETCH entry.
    ysyx_24120013_fetch_timer #(
        .TIMEOUT (IMEM_TIMEOUT)
    ) u_fetch_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_fetch),
        .tick    (wait_tick),
        .expired (timed_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RST;
        end else begin
            state <= state_nxt;
        end
    end

    // All outputs decode from the state register, so an asynchronous reset
    // forces them low immediately without waiting for a clock edge.
    // NOTE: every always_comb output gets a default first; a path that
    // forgets to assign would otherwise infer a latch.
    always_comb begin
        state_nxt  = state;
        imem_req   = 1'b0;
        imem_addr  = '0;
        rf_wen_out = 1'b0;
        pc_update  = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;

        case (state)
            ST_RST: begin
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc;
                // Bus error outranks a simultaneous rvalid.
                if (imem_err) begin
                    state_nxt = ST_FAULT;
                end else if (imem_rvalid) begin
                    state_nxt = ST_EXEC;
                end else if (timed_out) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_EXEC: begin
                rf_wen_out = rf_wen_in;
                if (halt_req) begin
                    state_nxt = ST_HALT;
                end else begin
                    pc_update = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                // Unused encodings park in FAULT so corruption is visible.
                state_nxt = ST_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_q <= '0;
        end else if (fetch_ok) begin
            inst_q <= imem_rdata;
        end
    end

    assign state_o = state;

`ifdef YSYX_24120013_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] instr_cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q;

    // Both counters wrap naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if ((state == ST_EXEC) && !halt_req) begin
                instr_cnt_q <= instr_cnt_q + 1'b1;
            end
            if (wait_tick) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign instr_cnt = instr_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign instr_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_24120013_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24120013_seq_ctrl
// Directed bench for the sequencer (IMEM_TIMEOUT = 4). Each cycle task
// drives inputs at the falling edge, then checks outputs against the state
// the bench expects. Fetched instructions go into a scoreboard queue and are
// popped/compared against inst_q in the following EXEC cycle.
// ---------------------------------------------------------------------------
module tb_ysyx_24120013_seq_ctrl;
    import ysyx_24120013_ctrl_pkg::*;

    localparam int          TMO  = 4;
    localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef YSYX_24120013_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic [31:0] inst_q;
    logic        rf_wen_in;
    logic        rf_wen_out;
    logic        pc_update;
    logic        halt_req;
    logic        halted;
    logic        fault;
    logic [2:0]  state_o;
    logic [31:0] instr_cnt;
    logic [31:0] stall_cnt;

    ysyx_24120013_seq_ctrl #(
        .IMEM_TIMEOUT (TMO),
        .CNT_WIDTH    (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .imem_err    (imem_err),
        .inst_q      (inst_q),
        .rf_wen_in   (rf_wen_in),
        .rf_wen_out  (rf_wen_out),
        .pc_update   (pc_update),
        .halt_req    (halt_req),
        .halted      (halted),
        .fault       (fault),
        .state_o     (state_o),
        .instr_cnt   (instr_cnt),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_inst;
    int unsigned instr_m;
    int unsigned stall_m;
    logic [31:0] pc_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int unsigned m);
        return 32'(m) & {32{PERF_EN}};
    endfunction

    // One clock cycle in state es with the given inputs.
    task automatic cycle(input logic rv, input logic er, input logic [31:0] rd,
                         input logic hr, input logic wn, input state_t es);
        @(negedge clk);
        imem_rvalid = rv;
        imem_err    = er;
        imem_rdata  = rd;
        halt_req    = hr;
        rf_wen_in   = wn;
        pc          = pc_m;
        #1;
        check("state", {29'd0, state_o}, 32'(es));
        check("imem_req", {31'd0, imem_req}, {31'd0, es == ST_FETCH});
        check("imem_addr", imem_addr, (es == ST_FETCH) ? pc_m : 32'd0);
        check("rf_wen_out", {31'd0, rf_wen_out}, {31'd0, (es == ST_EXEC) && wn});
        check("pc_update", {31'd0, pc_update}, {31'd0, (es == ST_EXEC) && !hr});
        check("halted", {31'd0, halted}, {31'd0, es == ST_HALT});
        check("fault", {31'd0, fault}, {31'd0, es == ST_FAULT});
        check("inst_q_hold", inst_q, exp_inst);
        check("instr_cnt", instr_cnt, cnt_exp(instr_m));
        check("stall_cnt", stall_cnt, cnt_exp(stall_m));
        if (es == ST_EXEC) begin
            if (sb.size() == 0) check("sb_empty", 32'(sb.size()), 32'd1);
            else                check("sb_inst", inst_q, sb.pop_front());
        end
        // Effects of the coming rising edge.
        if (es == ST_FETCH && rv && !er) begin
            sb.push_back(rd);
            exp_inst = rd;
        end
        if (es == ST_FETCH && !rv && !er) stall_m++;
        if (es == ST_EXEC && !hr) begin
            instr_m++;
            pc_m += 32'd4;
        end
    endtask

    // Assert reset now (no clock edge) and check every output clears at once.
    task automatic hit_reset();
        rst = 1'b0;
        #1;
        check("rst_state", {29'd0, state_o}, 32'(ST_RST));
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_pc_update", {31'd0, pc_update}, 32'd0);
        check("rst_rf_wen_out", {31'd0, rf_wen_out}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_inst_q", inst_q, 32'd0);
        check("rst_instr_cnt", instr_cnt, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        sb.delete();
        exp_inst = 32'd0;
        instr_m  = 0;
        stall_m  = 0;
        pc_m     = BASE;
    endtask

    // Release at a falling edge; the half cycle up to the next rise is RST.
    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_cycle_state", {29'd0, state_o}, 32'(ST_RST));
        check("rst_cycle_req", {31'd0, imem_req}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        hit_reset();
        release_rst();
    endtask

    initial begin
        rst         = 1'b0;
        pc          = BASE;
        imem_rvalid = 1'b1;
        imem_err    = 1'b0;
        imem_rdata  = 32'hdead_beef;
        halt_req    = 1'b0;
        rf_wen_in   = 1'b1;
        pc_m        = BASE;
        @(negedge clk);
        hit_reset();
        @(negedge clk);
        hit_reset();
        release_rst();

        // Back-to-back fetches: 2-cycle instruction period.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 32'h0010_0093, 1'b0, 1'b1, ST_FETCH);
            cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, ST_EXEC);
        end

        // Three silent cycles before each response: 5-cycle period.
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 3; j++) begin
                cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, ST_FETCH);
                if (i == 0 && j == 0) check("instr_cnt_after_20", instr_cnt, PERF_EN ? 32'd10 : 32'd0);
            end
            cycle(1'b1, 1'b0, 32'h1234_0000 + 32'(i), 1'b0, 1'b1, ST_FETCH);
            cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, ST_EXEC);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, ST_FETCH);
        check("stall_cnt_2x3", stall_cnt, PERF_EN ? 32'd6 : 32'd0);

        // Timeout: four silent FETCH cycles, then rvalid is ignored.
        do_reset();
        for (int j = 0; j < TMO; j++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, ST_FETCH);
        for (int j = 0; j < 3; j++)   cycle(1'b1, 1'b0, 32'h5555_aaaa, 1'b0, 1'b1, ST_FAULT);

        // Error together with rvalid: FAULT, inst_q keeps the previous word.
        do_reset();
        cycle(1'b1, 1'b0, 32'h0000_0513, 1'b0, 1'b1, ST_FETCH);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, ST_EXEC);
        cycle(1'b1, 1'b1, 32'hbad0_0bad, 1'b0, 1'b1, ST_FETCH);
        for (int j = 0; j < 2; j++) cycle(1'b1, 1'b0, 32'h7777_7777, 1'b0, 1'b1, ST_FAULT);
        check("err_inst_q", inst_q, 32'h0000_0513);

        // Halt with a write: one write pulse, no PC update, then sticky HALT.
        do_reset();
        cycle(1'b1, 1'b0, 32'h0010_0073, 1'b0, 1'b0, ST_FETCH);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, ST_EXEC);
        for (int j = 0; j < 3; j++) cycle(1'b1, j[0], 32'h0000_0093, 1'b0, 1'b1, ST_HALT);

        // Abort mid-FETCH (waiting) and mid-EXEC (write and PC update active).
        do_reset();
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, ST_FETCH);
        hit_reset();
        release_rst();
        cycle(1'b1, 1'b0, 32'h00a0_0113, 1'b0, 1'b1, ST_FETCH);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, ST_EXEC);
        hit_reset();
        release_rst();
        cycle(1'b1, 1'b0, 32'h00b0_0193, 1'b0, 1'b1, ST_FETCH);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, ST_EXEC);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, ST_FETCH);
        check("sb_left", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_24120013_seq_ctrl.md
YSYX_24120013_SEQ_CTRL -- requirements
Module: ysyx_24120013_seq_ctrl

Interface
REQ-001 SHALL have parameter IMEM_TIMEOUT, default 15, meaning the number of consecutive no-response FETCH cycles before a fault; 0 disables the timeout.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, meaning the performance counter width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low.
REQ-005 pc  in  32  current PC from the PC register.
REQ-006 imem_req  out  1  instruction fetch request.
REQ-007 imem_addr  out  32  fetch address; equals pc while imem_req=1, else 0.
REQ-008 imem_rvalid  in  1  fetch data valid.
REQ-009 imem_rdata  in  32  fetched instruction.
REQ-010 imem_err  in  1  fetch bus error; qualified with imem_rvalid-cycle semantics.
REQ-011 inst_q  out  32  latched instruction fed to IFU/IDU.
REQ-012 rf_wen_in  in  1  raw write enable from EXU.
REQ-013 rf_wen_out  out  1  gated register-file write enable.
REQ-014 pc_update  out  1  one-cycle PC advance/jump enable.
REQ-015 halt_req  in  1  decoded ebreak/halt from IDU.
REQ-016 halted  out  1  core halted (sticky).
REQ-017 fault  out  1  fetch fault (sticky).
REQ-018 state_o  out  3  current FSM state encoding, for debug.
REQ-019 instr_cnt  out  CNT_WIDTH  retired instruction count.
REQ-020 stall_cnt  out  CNT_WIDTH  FETCH wait-cycle count.

Function
REQ-021 The FSM SHALL have states RST=0, FETCH=1, EXEC=2, HALT=3, FAULT=4.
REQ-022 RST SHALL last exactly one cycle after reset release, with imem_req=0, then go to FETCH.
REQ-023 In FETCH, imem_req SHALL be 1 and held until a response; imem_rvalid/imem_err outside FETCH SHALL be ignored.
REQ-024 A FETCH cycle with imem_rvalid=1 and imem_err=0 SHALL latch imem_rdata into inst_q at that edge and go to EXEC.
REQ-025 A FETCH cycle with imem_err=1 (with or without rvalid) SHALL go to FAULT; error wins over rvalid.
REQ-026 Timeout: after IMEM_TIMEOUT consecutive FETCH cycles without rvalid/err, the next state SHALL be FAULT; a response arriving on the IMEM_TIMEOUT-th cycle wins; the wait counter SHALL clear on every FETCH entry.
REQ-027 EXEC SHALL last exactly one cycle, with rf_wen_out=rf_wen_in; in every other state rf_wen_out SHALL be 0.
REQ-028 EXEC with halt_req=0 SHALL assert pc_update=1 and go to FETCH; pc_update SHALL be 0 in all other cycles.
REQ-029 EXEC with halt_req=1 SHALL keep pc_update=0 and go to HALT; rf_wen_out still follows rf_wen_in.
REQ-030 HALT and FAULT SHALL be absorbing until reset; halted=1 only in HALT, fault=1 only in FAULT.
REQ-031 inst_q SHALL hold its value outside the latch edge.
REQ-032 Minimum instruction period SHALL be 2 cycles (1 FETCH with immediate rvalid + 1 EXEC).

Reset
REQ-033 While rst=0, the FSM SHALL be in RST and imem_req, pc_update, rf_wen_out, halted, fault, inst_q, the wait counter, instr_cnt and stall_cnt SHALL all be 0.
REQ-034 Reset asserted mid-FETCH or mid-EXEC SHALL abort immediately (asynchronously), with no PC update and no register write.

Configuration
REQ-035 With YSYX_24120013_PERF_CNT_EN defined: instr_cnt SHALL increment on each EXEC cycle with halt_req=0; stall_cnt SHALL increment on each FETCH cycle without a response; both SHALL wrap modulo 2^CNT_WIDTH.
REQ-036 Without YSYX_24120013_PERF_CNT_EN: instr_cnt and stall_cnt SHALL be constant 0, and no counter flops SHALL be inferred.

Structure
REQ-037 Package ysyx_24120013_ctrl_pkg SHALL hold the state enum typedef, the 3-bit state width and the 32-bit instruction/address width constants.
REQ-038 The timeout counter SHALL be sub-module ysyx_24120013_fetch_timer (inputs clear/tick, output expired); everything else stays in the FSM module.

Verification
REQ-039 rvalid=1 on every FETCH cycle, rdata=0x00100093, halt_req=0 -> pc_update pulses every 2nd cycle; inst_q=0x00100093; instr_cnt=10 after 20 cycles past RST.
REQ-040 rvalid delayed 3 cycles per fetch -> period 5 cycles; stall_cnt increments by 3 per instruction.
REQ-041 IMEM_TIMEOUT=4, no rvalid -> FAULT after 4 FETCH cycles, fault=1, imem_req=0; rvalid on the 4th cycle instead -> EXEC, no fault.
REQ-042 imem_err=1 together with rvalid=1 -> FAULT; inst_q unchanged; rf_wen_out is never asserted.
REQ-043 halt_req=1 with rf_wen_in=1 in EXEC -> rf_wen_out=1 for one cycle, pc_update=0, halted=1 thereafter; later rvalid pulses are ignored.
REQ-044 rst low mid-FETCH -> outputs 0 asynchronously; after release, one RST cycle then FETCH; with PERF_CNT_EN undefined, counters read 0 throughout.
